// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: divides CLOCK_50 into a one-cycle TICK with a runtime-loadable divisor.
// Optional SQUARE output (50% duty, period 2*div) when TICK_PRESCALER_SQUARE_EN is defined.
module tick_prescaler #(
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = 25000000,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic                 DIV_LOAD,
  input  logic [WIDTH-1:0]     DIV_VALUE,
  output logic                 TICK,
  output logic [CNT_WIDTH-1:0] TICK_COUNT,
  output logic                 BUSY
`ifdef TICK_PRESCALER_SQUARE_EN
  ,
  output logic                 SQUARE
`endif
);

  localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

  // A zero divisor saturates to one so the terminal compare never underflows.
  function automatic logic [WIDTH-1:0] sat_div(input logic [WIDTH-1:0] d);
    return (d == '0) ? WIDTH'(1) : d;
  endfunction

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] shadow;
  logic             pending;
  logic             terminal;

  always_comb begin
    terminal = (cnt == (sat_div(div) - WIDTH'(1)));
  end

  assign BUSY = pending;

  // New divisors only ever take effect when cnt returns to 0, so a shrinking
  // divisor can never leave cnt stranded above its terminal count.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      cnt        <= '0;
      div        <= RESET_DIV;
      shadow     <= '0;
      pending    <= 1'b0;
      TICK       <= 1'b0;
      TICK_COUNT <= '0;
    end else if (ENABLE) begin
      if (terminal) begin
        cnt        <= '0;
        TICK       <= 1'b1;
        TICK_COUNT <= TICK_COUNT + CNT_WIDTH'(1);
      end else begin
        cnt        <= cnt + WIDTH'(1);
        TICK       <= 1'b0;
      end
      // A load coinciding with a terminal count defers to the next one.
      if (DIV_LOAD) begin
        shadow  <= DIV_VALUE;
        pending <= 1'b1;
      end else if (terminal && pending) begin
        div     <= shadow;
        pending <= 1'b0;
      end
    end else begin
      TICK <= 1'b0;
      if (DIV_LOAD) begin
        div     <= DIV_VALUE;
        cnt     <= '0;
        pending <= 1'b0;
      end
    end
  end

`ifdef TICK_PRESCALER_SQUARE_EN
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      SQUARE <= 1'b0;
    end else if (ENABLE && terminal) begin
      SQUARE <= ~SQUARE;
    end
  end
`endif

endmodule

// File: tb/tb_tick_prescaler.sv
// Self-checking bench for tick_prescaler: table of per-cycle vectors fed through a scoreboard queue.
module tb_tick_prescaler;

  localparam int WIDTH = 26;
  localparam int CW    = 8;

  logic             CLOCK_50 = 1'b0;
  logic             RESET    = 1'b1;
  logic             ENABLE   = 1'b0;
  logic             DIV_LOAD = 1'b0;
  logic [WIDTH-1:0] DIV_VALUE = '0;
  logic             TICK;
  logic [CW-1:0]    TICK_COUNT;
  logic             BUSY;
`ifdef TICK_PRESCALER_SQUARE_EN
  logic             SQUARE;
`endif

  tick_prescaler #(.WIDTH(WIDTH), .DEFAULT_DIV(4), .CNT_WIDTH(CW)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .ENABLE    (ENABLE),
    .DIV_LOAD  (DIV_LOAD),
    .DIV_VALUE (DIV_VALUE),
    .TICK      (TICK),
    .TICK_COUNT(TICK_COUNT),
    .BUSY      (BUSY)
`ifdef TICK_PRESCALER_SQUARE_EN
    ,
    .SQUARE    (SQUARE)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    bit             rst;
    bit             en;
    bit             ld;
    logic [WIDTH-1:0] val;
    bit             tick;
    logic [CW-1:0]  cnt;
    bit             busy;
    bit             sq;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  bit   sq_m   = 1'b0;

  task automatic add(input bit rst, input bit en, input bit ld, input int val,
                     input bit tick, input int cnt, input bit busy);
    vec_t v;
    v.rst = rst; v.en = en; v.ld = ld; v.val = WIDTH'(val);
    v.tick = tick; v.cnt = CW'(cnt); v.busy = busy;
    if (rst) sq_m = 1'b0;
    else if (tick) sq_m = ~sq_m;
    v.sq = sq_m;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    RESET = v.rst; ENABLE = v.en; DIV_LOAD = v.ld; DIV_VALUE = v.val;
    exp_q.push_back(v);
    @(posedge CLOCK_50);
    #1;
    e = exp_q.pop_front();
    check($sformatf("tick[%0d]", idx), int'(TICK), int'(e.tick));
    check($sformatf("count[%0d]", idx), int'(TICK_COUNT), int'(e.cnt));
    check($sformatf("busy[%0d]", idx), int'(BUSY), int'(e.busy));
`ifdef TICK_PRESCALER_SQUARE_EN
    check($sformatf("square[%0d]", idx), int'(SQUARE), int'(e.sq));
`endif
  endtask

  task automatic drive(input bit en, input bit ld, input int val);
    RESET = 1'b0; ENABLE = en; DIV_LOAD = ld; DIV_VALUE = WIDTH'(val);
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    int waited;
    // reset
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,0,0);
    // default divisor 4: ticks at 4, 8, 12
    for (int i = 1; i <= 12; i++) add(0,1,0,0, (i % 4) == 0, i / 4, 0);
    add(1,1,0,0, 0,0,0);
    // load 2 at cnt=1: period still ends at 4, then every 2
    add(0,1,0,0, 0,0,0);
    add(0,1,1,2, 0,0,1);
    add(0,1,0,0, 0,0,1);
    add(0,1,0,0, 1,1,0);
    add(0,1,0,0, 0,1,0);
    add(0,1,0,0, 1,2,0);
    add(0,1,0,0, 0,2,0);
    add(0,1,0,0, 1,3,0);
    // load 3 on a terminal count: applies only after the next period
    add(0,1,0,0, 0,3,0);
    add(0,1,1,3, 1,4,1);
    add(0,1,0,0, 0,4,1);
    add(0,1,0,0, 1,5,0);
    add(0,1,0,0, 0,5,0);
    add(0,1,0,0, 0,5,0);
    add(0,1,0,0, 1,6,0);
    // two loads while pending: last one (2) wins
    add(0,1,1,7, 0,6,1);
    add(0,1,1,2, 0,6,1);
    add(0,1,0,0, 1,7,0);
    add(0,1,0,0, 0,7,0);
    add(0,1,0,0, 1,8,0);
    // disabled load of 5, two enabled cycles, 7 idle, resume
    add(0,0,1,5, 0,8,0);
    add(0,1,0,0, 0,8,0);
    add(0,1,0,0, 0,8,0);
    for (int i = 0; i < 7; i++) add(0,0,0,0, 0,8,0);
    add(0,1,0,0, 0,8,0);
    add(0,1,0,0, 0,8,0);
    add(0,1,0,0, 1,9,0);
    // reset with cnt=3 and load of 1 pending: shadow must be discarded
    add(0,1,0,0, 0,9,0);
    add(0,1,1,1, 0,9,1);
    add(0,1,0,0, 0,9,1);
    add(1,1,0,0, 0,0,0);
    for (int i = 1; i <= 8; i++) add(0,1,0,0, (i % 4) == 0, i / 4, 0);
    // divisor 0 behaves as 1: tick every cycle, count wraps 255->0
    add(0,0,1,0, 0,2,0);
    for (int i = 1; i <= 260; i++) add(0,1,0,0, 1, (2 + i) % 256, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Hand sequence: divisor 5, hold at cnt=2, next TICK 3 enabled cycles later.
    drive(1'b0, 1'b1, 5);
    drive(1'b1, 1'b0, 0);
    drive(1'b1, 1'b0, 0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 0);
      check($sformatf("hold_tick[%0d]", i), int'(TICK), 0);
    end
    waited = 0;
    do begin
      drive(1'b1, 1'b0, 0);
      waited++;
    end while (!TICK && waited < 20);
    check("resume_latency", waited, 3);
    drive(1'b1, 1'b0, 0);
    check("resume_tick_width", int'(TICK), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tick_prescaler.md
Name: tick_prescaler

Overview:
- Clock-enable generator that sits directly upstream of the LED blinker.
- Divides CLOCK_50 into a one-cycle TICK strobe. The blinker qualifies its state toggle with TICK, so the LED toggle rate drops to human-visible speed without a derived clock.
- The divisor can be changed at runtime without glitches. A wrapping tick counter is provided for the pattern logic downstream.

Parameters:
- WIDTH, 26, width of the divisor and of the cycle counter.
- DEFAULT_DIV, 25000000, divisor loaded at reset (one TICK every 0.5 s at 50 MHz).
- CNT_WIDTH, 8, width of TICK_COUNT.

Ports:
- CLOCK_50  input  1  system clock; the only clock in the block.
- RESET  input  1  synchronous, active-high reset.
- ENABLE  input  1  count enable; when low, the counter holds.
- DIV_LOAD  input  1  one-cycle strobe that captures DIV_VALUE.
- DIV_VALUE  input  WIDTH  requested divisor, in cycles per TICK.
- TICK  output  1  registered, one CLOCK_50 cycle wide strobe.
- TICK_COUNT  output  CNT_WIDTH  number of TICKs issued, modulo 2^CNT_WIDTH.
- BUSY  output  1  high while a loaded divisor is waiting to be applied.

Behaviour:
- Reset (sampled on the CLOCK_50 rising edge):
  - cnt = 0, div = DEFAULT_DIV, pending = 0.
  - TICK = 0, TICK_COUNT = 0, BUSY = 0.
  - Any pending load is discarded.
- Effective divisor: div_eff = max(div, 1). A DIV_VALUE of 0 is treated as 1, which gives TICK every cycle while ENABLE is high.
- Counting with ENABLE = 1:
  - If cnt == div_eff-1, then cnt <= 0 and TICK <= 1 on the same edge. TICK is therefore high during the cycle after the terminal count is reached.
  - Otherwise cnt <= cnt+1 and TICK <= 0.
- TICK period with ENABLE held high is exactly div_eff cycles. The first TICK after reset is asserted div_eff cycles after RESET deasserts.
- ENABLE = 0: cnt holds, TICK <= 0, TICK_COUNT holds. When ENABLE reasserts, counting resumes from the held cnt; no phase is lost.
- TICK_COUNT increments by 1 on every edge that sets TICK, and wraps from 2^CNT_WIDTH-1 to 0.
- Divisor load with ENABLE = 1:
  - On DIV_LOAD = 1, DIV_VALUE is captured into shadow, pending <= 1 and BUSY <= 1.
  - At the next terminal count, div <= shadow and pending <= 0. That period completes with the old divisor, and the following period uses the new one.
  - DIV_LOAD in the same cycle as a terminal count: the current TICK is issued with the old divisor, and the new divisor applies from the period after next. It is never applied mid-period.
  - A second DIV_LOAD while pending overwrites shadow; the last value wins.
- Divisor load with ENABLE = 0:
  - div <= DIV_VALUE and cnt <= 0 immediately; pending stays 0.
  - The first TICK follows div_eff enabled cycles later.
- Shrinking divisor: if a new div is applied while cnt >= div_eff, the counter must still reach terminal count. Because apply only happens at cnt = 0, no overrun is possible; the implementation must preserve this invariant.
- Arithmetic: cnt, div and shadow are WIDTH bits unsigned. No output is combinational from any input.
- RESET asserted mid-period: everything returns to reset values on that edge, with no TICK.

Optional Feature:
- Macro: TICK_PRESCALER_SQUARE_EN.
- Defined: adds an output port SQUARE (1 bit).
  - Reset value 0.
  - Toggles on every edge that sets TICK, giving a 50%-duty square wave with period 2*div_eff.
  - Holds while ENABLE = 0.
  - Allows direct LED drive without a blinker.
- Not defined: the SQUARE port and its register do not exist. All other behaviour is identical.

Test Plan:
- DEFAULT_DIV=4, RESET for 2 cycles, then ENABLE=1 -> TICK high in cycles 4, 8, 12 after reset release, each exactly 1 cycle wide; TICK_COUNT reads 1, 2, 3.
- DEFAULT_DIV=4, DIV_LOAD with DIV_VALUE=2 at cnt=1 -> the current period still ends after 4 cycles, then TICKs every 2 cycles. BUSY is high from the load until the apply edge, then 0.
- DIV_LOAD with DIV_VALUE=0 while ENABLE=0, then ENABLE=1 -> TICK high every cycle; TICK_COUNT increments every cycle and wraps 255->0 with CNT_WIDTH=8.
- DEFAULT_DIV=5, ENABLE dropped for 7 cycles at cnt=2 -> no TICK while low; the next TICK arrives 3 enabled cycles after ENABLE reasserts.
- RESET pulsed one cycle with cnt=3 and a load pending -> the next edge shows cnt=0, TICK=0, TICK_COUNT=0, BUSY=0; the old shadow value is never applied.
- TICK_PRESCALER_SQUARE_EN defined, DEFAULT_DIV=3 -> SQUARE is 0 for 3 cycles, then 1 for 3, repeating; it toggles on the same edges as TICK.
